// File: rtl/j1_dbus_arbiter.sv
// Data-RAM arbiter: the J1 core data bus has absolute priority, and a host port
// (loader/DMA) is served in strobe-free cycles. Includes a stall counter and a protocol monitor.
module j1_dbus_arbiter #(
    parameter int RAM_AW = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       c_adr,
    input  logic              c_re,
    input  logic              c_we,
    input  logic [15:0]       c_dat_w,
    output logic [15:0]       c_dat_r,
    input  logic              h_valid,
    output logic              h_ready,
    input  logic              h_we,
    input  logic [15:0]       h_adr,
    input  logic [15:0]       h_dat_w,
    output logic              h_done,
    output logic [15:0]       h_dat_r,
    output logic [RAM_AW-1:0] m_adr,
    output logic              m_re,
    output logic              m_we,
    output logic [15:0]       m_dat_w,
    input  logic [15:0]       m_dat_r,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                core_stb_s;
    logic                accept_s;
    logic                issue_s;
    logic                h_we_r;
    logic [RAM_AW-1:0]   h_adr_r;
    logic [15:0]         h_dat_w_r;
    logic                h_rd_q;
    logic [RAM_AW-1:0]   m_adr_hold_r;
    logic [15:0]         m_dat_w_hold_r;
    logic                prev_stb_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic                proto_err_r;
    logic                unused_adr_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign core_stb_s   = c_re | c_we;
    assign h_ready      = (state_r != PEND);
    assign accept_s     = h_valid & h_ready;
    assign issue_s      = (state_r == PEND) & ~core_stb_s;
    assign c_dat_r      = m_dat_r;
    assign stall_cnt    = stall_cnt_r;
    assign proto_err    = proto_err_r;
    // Upper address bits beyond the RAM are intentionally dropped.
    assign unused_adr_s = ^{c_adr, h_adr};

    // Next-state logic, RAM port steering and host completion outputs
    always_comb begin
        state_s = state_r;
        m_re    = 1'b0;
        m_we    = 1'b0;
        m_adr   = m_adr_hold_r;
        m_dat_w = m_dat_w_hold_r;
        h_done  = 1'b0;
        h_dat_r = 16'h0000;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = PEND;
                end else begin
                    state_s = IDLE;
                end
            end
            PEND: begin
                if (issue_s) begin
                    state_s = DONE;
                end else begin
                    state_s = PEND;
                end
            end
            DONE: begin
                h_done = 1'b1;
                if (h_rd_q) begin
                    h_dat_r = m_dat_r;
                end else begin
                    h_dat_r = 16'h0000;
                end
                if (accept_s) begin
                    state_s = PEND;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (core_stb_s) begin
            m_adr   = c_adr[RAM_AW-1:0];
            m_re    = c_re;
            m_we    = c_we;
            m_dat_w = c_dat_w;
        end else if (issue_s) begin
            m_adr   = h_adr_r;
            m_re    = ~h_we_r;
            m_we    = h_we_r;
            m_dat_w = h_dat_w_r;
        end else begin
            m_re    = 1'b0;
            m_we    = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture an accepted host request; remember whether the issued access was a read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_we_r    <= 1'b0;
            h_adr_r   <= {RAM_AW{1'b0}};
            h_dat_w_r <= 16'h0000;
            h_rd_q    <= 1'b0;
        end else begin
            if (accept_s) begin
                h_we_r    <= h_we;
                h_adr_r   <= h_adr[RAM_AW-1:0];
                h_dat_w_r <= h_dat_w;
            end
            if (issue_s) begin
                h_rd_q <= ~h_we_r;
            end
        end
    end

    // Idle RAM port keeps presenting the last address/data instead of toggling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_adr_hold_r   <= {RAM_AW{1'b0}};
            m_dat_w_hold_r <= 16'h0000;
        end else if (m_re | m_we) begin
            m_adr_hold_r   <= m_adr;
            m_dat_w_hold_r <= m_dat_w;
        end
    end

    // Contention counter: counts cycles a pending host request loses to the core
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == PEND) && core_stb_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end
    end

    // Sticky monitor for core strobe rules (exclusive strobes, mandatory gap cycle)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_stb_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            prev_stb_r <= core_stb_s;
            if ((c_re & c_we) | (core_stb_s & prev_stb_r)) begin
                proto_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_j1_dbus_arbiter.sv
// Self-checking bench for j1_dbus_arbiter: directed vector table, corner sequences,
// and randomized traffic checked against a transaction-level model with a shadow memory.
module tb_j1_dbus_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] c_adr;
    logic        c_re;
    logic        c_we;
    logic [15:0] c_dat_w;
    logic [15:0] c_dat_r;
    logic        h_valid;
    logic        h_ready;
    logic        h_we;
    logic [15:0] h_adr;
    logic [15:0] h_dat_w;
    logic        h_done;
    logic [15:0] h_dat_r;
    logic [7:0]  m_adr;
    logic        m_re;
    logic        m_we;
    logic [15:0] m_dat_w;
    logic [15:0] m_dat_r;
    logic [1:0]  stall_cnt;
    logic        stall_clr;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    j1_dbus_arbiter #(.RAM_AW(8), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .c_adr(c_adr), .c_re(c_re), .c_we(c_we), .c_dat_w(c_dat_w), .c_dat_r(c_dat_r),
        .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_adr(h_adr),
        .h_dat_w(h_dat_w), .h_done(h_done), .h_dat_r(h_dat_r),
        .m_adr(m_adr), .m_re(m_re), .m_we(m_we), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (b == 8'h10) pat = 16'hBEEF;
        else            pat = {b ^ 8'hC3, ~b};
    endfunction

    // One-cycle-latency single-port RAM, preloaded while ram_fill is high
    logic        ram_fill;
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
        end else if (m_we) begin
            ram[m_adr] <= m_dat_w;
        end
        if (m_re) m_dat_r <= ram[m_adr];
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_re = 1'b0; c_we = 1'b0; c_adr = 16'h0000; c_dat_w = 16'h0000;
        h_valid = 1'b0; h_we = 1'b0; h_adr = 16'h0000; h_dat_w = 16'h0000;
        stall_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        ram_fill = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        ram_fill = 1'b0;
    endtask

    typedef struct {
        logic c_re; logic c_we; logic [15:0] c_adr; logic [15:0] c_dat_w;
        logic h_valid; logic h_we; logic [15:0] h_adr; logic [15:0] h_dat_w;
        logic e_ready; logic e_done; logic [15:0] e_hdat;
        logic e_mre; logic e_mwe; logic [7:0] e_madr; logic [15:0] e_mdatw;
        logic e_cchk; logic [15:0] e_cdat; logic [1:0] e_stall;
    } vec_t;

    vec_t vt [20];

    // Reference model state
    logic [15:0] shadow [256];
    logic        pend, q_we, done_now, done_rd, prev_stb, cdat_valid;
    logic [7:0]  q_adr;
    logic [15:0] q_dat, done_data, cdat_exp;
    int          stall_m;
    logic        stb, issue, e_re, e_we;
    logic [7:0]  e_adr;
    logic [15:0] e_dat;

    initial begin
        reset = 1'b1;
        ram_fill = 1'b1;
        idle_inputs();

        //          c_re  c_we  c_adr     c_dat_w   h_v   h_we  h_adr     h_dat_w   rdy   done  h_dat_r   m_re  m_we  m_adr  m_dat_w   cchk  c_dat_r   stall
        vt[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd0};
        vt[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h0000, 2'd0};
        vt[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd0};
        vt[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd0};
        vt[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd0};
        vt[5]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 2'd0};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h20, 16'h1234, 1'b1, 16'hC6FA, 2'd1};
        vt[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd1};
        vt[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd1};
        vt[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h30, 16'h1234, 1'b0, 16'h0000, 2'd1};
        vt[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h8130, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd1};
        vt[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 16'h0000, 2'd1};
        vt[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd1};
        vt[13] = '{1'b0, 1'b1, 16'hFF44, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h44, 16'hA5A5, 1'b0, 16'h0000, 2'd1};
        vt[14] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd1};
        vt[15] = '{1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h44, 16'h0000, 1'b0, 16'h0000, 2'd1};
        vt[16] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 16'hA5A5, 2'd1};
        vt[17] = '{1'b0, 1'b1, 16'h0010, 16'h7777, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h10, 16'h7777, 1'b0, 16'h0000, 2'd1};
        vt[18] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h44, 16'h0000, 1'b0, 16'h0000, 2'd1};
        vt[19] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2'd1};

        do_reset();
        @(negedge clk);
        chk("rst_h_ready", 16'(h_ready), 16'h0001);
        chk("rst_h_done", 16'(h_done), 16'h0000);
        chk("rst_h_dat_r", h_dat_r, 16'h0000);
        chk("rst_m_re", 16'(m_re), 16'h0000);
        chk("rst_m_we", 16'(m_we), 16'h0000);
        chk("rst_m_adr", 16'(m_adr), 16'h0000);
        chk("rst_m_dat_w", m_dat_w, 16'h0000);
        chk("rst_stall_cnt", 16'(stall_cnt), 16'h0000);
        chk("rst_proto_err", 16'(proto_err), 16'h0000);

        // Directed vector table
        for (int r = 0; r < 20; r++) begin
            tick();
            c_re = vt[r].c_re; c_we = vt[r].c_we; c_adr = vt[r].c_adr; c_dat_w = vt[r].c_dat_w;
            h_valid = vt[r].h_valid; h_we = vt[r].h_we; h_adr = vt[r].h_adr; h_dat_w = vt[r].h_dat_w;
            stall_clr = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_h_ready", r), 16'(h_ready), 16'(vt[r].e_ready));
            chk($sformatf("vec%0d_h_done", r), 16'(h_done), 16'(vt[r].e_done));
            chk($sformatf("vec%0d_h_dat_r", r), h_dat_r, vt[r].e_hdat);
            chk($sformatf("vec%0d_m_re", r), 16'(m_re), 16'(vt[r].e_mre));
            chk($sformatf("vec%0d_m_we", r), 16'(m_we), 16'(vt[r].e_mwe));
            if (vt[r].e_mre || vt[r].e_mwe) chk($sformatf("vec%0d_m_adr", r), 16'(m_adr), 16'(vt[r].e_madr));
            if (vt[r].e_mwe) chk($sformatf("vec%0d_m_dat_w", r), m_dat_w, vt[r].e_mdatw);
            if (vt[r].e_cchk) chk($sformatf("vec%0d_c_dat_r", r), c_dat_r, vt[r].e_cdat);
            chk($sformatf("vec%0d_stall_cnt", r), 16'(stall_cnt), 16'(vt[r].e_stall));
            chk($sformatf("vec%0d_proto_err", r), 16'(proto_err), 16'h0000);
        end

        // Saturation of a 2-bit counter, then clear
        tick(); idle_inputs(); stall_clr = 1'b1;
        @(negedge clk);
        tick(); stall_clr = 1'b0;
        @(negedge clk);
        chk("sat_clr_first", 16'(stall_cnt), 16'h0000);
        for (int k = 0; k < 5; k++) begin
            tick(); idle_inputs(); h_valid = 1'b1; h_we = 1'b0; h_adr = 16'(16'h0060 + k);
            @(negedge clk);
            chk("sat_accept_ready", 16'(h_ready), 16'h0001);
            chk("sat_accept_done", 16'(h_done), (k > 0) ? 16'h0001 : 16'h0000);
            tick(); h_valid = 1'b0; c_re = 1'b1; c_adr = 16'h0070;
            @(negedge clk);
            chk("sat_core_m_adr", 16'(m_adr), 16'h0070);
            chk("sat_core_h_ready", 16'(h_ready), 16'h0000);
            tick(); c_re = 1'b0;
            @(negedge clk);
            chk("sat_host_m_re", 16'(m_re), 16'h0001);
            chk("sat_host_m_adr", 16'(m_adr), 16'(16'h0060 + k));
            chk("sat_stall_cnt", 16'(stall_cnt), (k >= 2) ? 16'h0003 : 16'(k + 1));
        end
        tick(); idle_inputs();
        @(negedge clk);
        chk("sat_final_done", 16'(h_done), 16'h0001);
        chk("sat_stuck", 16'(stall_cnt), 16'h0003);
        tick(); stall_clr = 1'b1;
        @(negedge clk);
        chk("sat_clr_pending", 16'(stall_cnt), 16'h0003);
        tick(); stall_clr = 1'b0;
        @(negedge clk);
        chk("sat_clr_zero", 16'(stall_cnt), 16'h0000);

        // Protocol error: consecutive core strobes
        tick(); c_re = 1'b1; c_adr = 16'h0001;
        @(negedge clk);
        chk("proto_first_stb", 16'(proto_err), 16'h0000);
        tick(); c_adr = 16'h0002;
        @(negedge clk);
        chk("proto_second_stb", 16'(proto_err), 16'h0000);
        tick(); c_re = 1'b0;
        @(negedge clk);
        chk("proto_set_consec", 16'(proto_err), 16'h0001);
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("proto_sticky", 16'(proto_err), 16'h0001);
        end
        do_reset();
        @(negedge clk);
        chk("proto_cleared_by_reset", 16'(proto_err), 16'h0000);
        tick(); c_re = 1'b1; c_we = 1'b1; c_adr = 16'h0003; c_dat_w = 16'h0F0F;
        @(negedge clk);
        tick(); idle_inputs();
        @(negedge clk);
        chk("proto_set_re_we", 16'(proto_err), 16'h0001);
        do_reset();

        // Reset while a host write is pending
        tick(); h_valid = 1'b1; h_we = 1'b1; h_adr = 16'h0050; h_dat_w = 16'hDEAD;
        @(negedge clk);
        tick(); h_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rstpend_h_ready", 16'(h_ready), 16'h0001);
        chk("rstpend_m_we", 16'(m_we), 16'h0000);
        chk("rstpend_h_done", 16'(h_done), 16'h0000);
        tick(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstpend_after_done", 16'(h_done), 16'h0000);
            chk("rstpend_after_m_we", 16'(m_we), 16'h0000);
            chk("rstpend_after_ready", 16'(h_ready), 16'h0001);
            tick();
        end
        c_re = 1'b1; c_adr = 16'h0050;
        @(negedge clk);
        tick(); c_re = 1'b0;
        @(negedge clk);
        chk("rstpend_ram_untouched", c_dat_r, pat(16'h0050));

        // Randomized traffic against the transaction model
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        pend = 1'b0; q_we = 1'b0; q_adr = 8'h00; q_dat = 16'h0000;
        done_now = 1'b0; done_rd = 1'b0; done_data = 16'h0000;
        prev_stb = 1'b0; cdat_valid = 1'b0; cdat_exp = 16'h0000; stall_m = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            idle_inputs();
            if (!prev_stb && ($urandom_range(0, 9) < 4)) begin
                if ($urandom_range(0, 1) == 0) c_re = 1'b1;
                else                           c_we = 1'b1;
                c_adr = 16'($urandom);
                c_dat_w = 16'($urandom);
            end
            h_valid = ($urandom_range(0, 1) == 1);
            h_we = ($urandom_range(0, 1) == 1);
            h_adr = 16'($urandom);
            h_dat_w = 16'($urandom);
            stall_clr = ($urandom_range(0, 19) == 0);
            stb = c_re | c_we;
            @(negedge clk);
            if (stb) begin
                e_re = c_re; e_we = c_we; e_adr = c_adr[7:0]; e_dat = c_dat_w;
            end else if (pend) begin
                e_re = !q_we; e_we = q_we; e_adr = q_adr; e_dat = q_dat;
            end else begin
                e_re = 1'b0; e_we = 1'b0; e_adr = 8'h00; e_dat = 16'h0000;
            end
            chk("rnd_h_ready", 16'(h_ready), 16'(!pend));
            chk("rnd_h_done", 16'(h_done), 16'(done_now));
            chk("rnd_h_dat_r", h_dat_r, (done_now && done_rd) ? done_data : 16'h0000);
            chk("rnd_m_re", 16'(m_re), 16'(e_re));
            chk("rnd_m_we", 16'(m_we), 16'(e_we));
            if (e_re || e_we) chk("rnd_m_adr", 16'(m_adr), 16'(e_adr));
            if (e_we) chk("rnd_m_dat_w", m_dat_w, e_dat);
            if (cdat_valid) chk("rnd_c_dat_r", c_dat_r, cdat_exp);
            chk("rnd_stall_cnt", 16'(stall_cnt), 16'(stall_m));
            chk("rnd_proto_err", 16'(proto_err), 16'h0000);

            issue = pend && !stb;
            if (issue) begin
                done_rd = !q_we;
                done_data = q_we ? 16'h0000 : shadow[q_adr];
                if (q_we) shadow[q_adr] = q_dat;
            end
            if (stb) begin
                cdat_valid = c_re;
                if (c_re) cdat_exp = shadow[c_adr[7:0]];
                if (c_we) shadow[c_adr[7:0]] = c_dat_w;
            end else begin
                cdat_valid = 1'b0;
            end
            if (stall_clr)                          stall_m = 0;
            else if (pend && stb && stall_m < 3)    stall_m = stall_m + 1;
            if (h_valid && !pend) begin
                pend = 1'b1; q_we = h_we; q_adr = h_adr[7:0]; q_dat = h_dat_w;
            end else if (issue) begin
                pend = 1'b0;
            end
            done_now = issue;
            prev_stb = stb;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/j1_dbus_arbiter.md
# j1_dbus_arbiter

Two-master data-memory arbiter between the J1 core data bus and a host port (debug loader / DMA) that shares one single-port, one-cycle-read-latency data RAM. The core always has absolute priority and never stalls. The host is served only in cycles where the core issues no strobe. The block sits between `j1_core`'s data bus and the data RAM, with the host side driven by the debug/loader logic.

## Interface
- `RAM_AW`, default 15: RAM word-address width. Address bits above `RAM_AW` are ignored.
- `CNT_W`, default 16: width of the contention counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `c_adr`  in  16  core word address
- `c_re`  in  1  core read strobe, single cycle
- `c_we`  in  1  core write strobe, single cycle
- `c_dat_w`  in  16  core write data
- `c_dat_r`  out  16  core read data, valid the cycle after `c_re`
- `h_valid`  in  1  host request valid
- `h_ready`  out  1  host request accepted when `h_valid & h_ready`
- `h_we`  in  1  host request is a write (0 = read)
- `h_adr`  in  16  host word address
- `h_dat_w`  in  16  host write data
- `h_done`  out  1  one-cycle completion pulse
- `h_dat_r`  out  16  host read data, valid with `h_done` for reads
- `m_adr`  out  `RAM_AW`  RAM word address
- `m_re`  out  1  RAM read enable
- `m_we`  out  1  RAM write enable
- `m_dat_w`  out  16  RAM write data
- `m_dat_r`  in  16  RAM read data, valid one cycle after `m_re`
- `stall_cnt`  out  `CNT_W`  saturating count of host-blocked cycles
- `stall_clr`  in  1  synchronous clear of `stall_cnt`
- `proto_err`  out  1  sticky: core protocol violation seen

## Operation
- States: `IDLE`, `PEND`, `DONE`.
- `h_ready` is 1 in `IDLE` and `DONE`, and 0 in `PEND`.
- On accept, `h_we`, `h_adr` and `h_dat_w` are registered, and the state goes to `PEND`.
- Core path is combinational and always wins:
  - If `c_re | c_we`: `m_adr = c_adr[RAM_AW-1:0]`, `m_re = c_re`, `m_we = c_we`, `m_dat_w = c_dat_w`.
- In `PEND` with no core strobe:
  - The registered host request drives the RAM port.
  - The state goes to `DONE`.
  - Registered flag `h_rd_q` is set to `~h_we`.
- In `PEND` with a core strobe: the state stays in `PEND` and `stall_cnt` increments.
- In `DONE`:
  - `h_done = 1`.
  - `h_dat_r = m_dat_r` if `h_rd_q`, else 0.
  - Next state is `PEND` if a new request is accepted this cycle, else `IDLE`.
- Idle RAM port: `m_re = m_we = 0`, and `m_adr` / `m_dat_w` hold their last value (don't-care).
- `c_dat_r = m_dat_r` unconditionally. The RAM read data is shared, and only one read is issued per cycle.
- `stall_cnt`:
  - Saturates at all-ones.
  - `stall_clr` has priority over increment.
- `proto_err` is set, and stays set until reset, on any of:
  - `c_re & c_we` in the same cycle;
  - a core strobe in two consecutive cycles.
- The J1 core guarantees a strobe-free cycle after every strobe, because of its memory wait state. This bounds host wait to at most 1 blocked cycle per issue attempt.

## Timing
- Reset values:
  - state `IDLE`, `h_ready = 1`, `h_done = 0`, `h_dat_r = 0`;
  - `m_re = m_we = 0`, `m_adr = 0`, `m_dat_w = 0`;
  - `stall_cnt = 0`, `proto_err = 0`.
- Host latency with no contention: accept at cycle N, RAM access at N+1, `h_done` at N+2. Each blocked cycle adds 1.
- Core latency: zero added. RAM strobe is in the same cycle as the core strobe, and data is returned the next cycle.
- Back-to-back host requests: accept in `DONE` gives one access every 2 cycles.
- Simultaneous core strobe and host issue: core granted, host deferred. No lost or merged writes.
- Reset mid-operation (`PEND` or `DONE`): the pending request is discarded, no `h_done` is produced, and no RAM strobe occurs.
- Addresses wrap modulo 2^`RAM_AW`. Bits `[15:RAM_AW]` are ignored without error.

## Test plan
- Host read, core idle:
  - RAM[0x10] = 0xBEEF.
  - Accept at cycle 0 -> `m_re` with `m_adr = 0x10` at cycle 1; `h_done = 1`, `h_dat_r = 0xBEEF` at cycle 2; `stall_cnt = 0`.
- Contention:
  - Host write 0x1234 to 0x20 accepted at cycle 0, core `c_re` to 0x05 at cycle 1.
  - -> cycle 1: `m_adr = 0x05`; cycle 2: host write issued; cycle 3: `h_done`.
  - `stall_cnt = 1`; `c_dat_r` correct at cycle 2.
- Host write then read:
  - Write 0x20 = 0x1234, then read 0x20, issued back-to-back.
  - -> second accept in `DONE`; read returns 0x1234 at cycle 4.
- Saturation:
  - Force core strobes every other cycle against a pending host request, with `CNT_W = 2`.
  - -> `stall_cnt` sticks at 3; `stall_clr` gives 0 the next cycle.
- Protocol error:
  - `c_re` on two consecutive cycles -> `proto_err = 1`, held until reset.
  - `c_re & c_we` together also sets it.
- Reset in `PEND`: assert `reset` for 1 cycle -> no `h_done`, no `m_we`, `h_ready = 1`, state `IDLE`.
